// File: rtl/alu_sequencer_pkg.sv
// Shared types and bus/load code constants for the ALU sequencer and its opcode decoder.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_ADC  = 4'd1,  OP_SUB  = 4'd2,  OP_SBC  = 4'd3,
    OP_AND  = 4'd4,  OP_OR   = 4'd5,  OP_XOR  = 4'd6,  OP_NOT  = 4'd7,
    OP_SHL  = 4'd8,  OP_RCL  = 4'd9,  OP_SWAP = 4'd10, OP_CMP  = 4'd11,
    OP_MOV  = 4'd12, OP_ADDW = 4'd13, OP_SUBW = 4'd14, OP_NOP  = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_EXEC, S_SETUP2, S_EXEC2, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    CIN_ZERO, CIN_ONE, CIN_CARRY
  } cin_src_e;

  localparam logic [3:0] OUT_ADDSUB    = 4'd2;
  localparam logic [3:0] OUT_ANDOR     = 4'd6;
  localparam logic [3:0] OUT_SHIFTSWAP = 4'd7;
  localparam logic [3:0] OUT_XORNOT    = 4'd10;
  localparam logic [3:0] OUT_NONE      = 4'd3;

  localparam logic [3:0] LOAD_A    = 4'd0;
  localparam logic [3:0] LOAD_B    = 4'd1;
  localparam logic [3:0] LOAD_C    = 4'd8;
  localparam logic [3:0] LOAD_D    = 4'd9;
  localparam logic [3:0] LOAD_NONE = 4'd3;

  localparam logic [2:0] ARG_R_ZERO = 3'd6;

  typedef struct packed {
    logic [3:0] unit;
    logic       alt;
    cin_src_e   cin_src;
    logic       writes_dst;
    logic       sets_flags;
    logic       wide;
    logic       r_zero;
    logic       nop;
  } op_ctl_t;

  function automatic logic [3:0] load_code(input logic [1:0] r);
    case (r)
      2'd0:    load_code = LOAD_A;
      2'd1:    load_code = LOAD_B;
      2'd2:    load_code = LOAD_C;
      default: load_code = LOAD_D;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command handshake plus ALU control bus between decoder, sequencer and ALU block.
interface alu_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [1:0] cmd_dst;
  logic [1:0] cmd_src_l;
  logic [1:0] cmd_src_r;
  logic [3:0] flags;
  logic [3:0] outctl;
  logic [3:0] loadctl;
  logic [1:0] arg_l;
  logic [2:0] arg_r;
  logic       alt;
  logic       cin;
  logic       calcfn;
  logic       busy;
  logic       done;

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src_l, cmd_src_r, flags,
    input  cmd_ready, outctl, loadctl, arg_l, arg_r, alt, cin, calcfn, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src_l, cmd_src_r, flags,
    output cmd_ready, outctl, loadctl, arg_l, arg_r, alt, cin, calcfn, busy, done
  );
endinterface

// File: rtl/alu_sequencer_decode.sv
// Combinational opcode decode: result unit, alternate select, carry-in source and op class.
module alu_op_decode
  import alu_seq_pkg::*;
(
  input  logic [3:0] op_i,
  output op_ctl_t    ctl_o
);

  always_comb begin
    ctl_o = '{unit: OUT_ADDSUB, alt: 1'b0, cin_src: CIN_ZERO, writes_dst: 1'b1,
              sets_flags: 1'b1, wide: 1'b0, r_zero: 1'b0, nop: 1'b0};
    case (opcode_e'(op_i))
      OP_ADD:  ;
      OP_ADC:  ctl_o.cin_src = CIN_CARRY;
      OP_SUB:  begin ctl_o.alt = 1'b1; ctl_o.cin_src = CIN_ONE;   end
      OP_SBC:  begin ctl_o.alt = 1'b1; ctl_o.cin_src = CIN_CARRY; end
      OP_AND:  ctl_o.unit = OUT_ANDOR;
      OP_OR:   begin ctl_o.unit = OUT_ANDOR;  ctl_o.alt = 1'b1; end
      OP_XOR:  ctl_o.unit = OUT_XORNOT;
      OP_NOT:  begin ctl_o.unit = OUT_XORNOT; ctl_o.alt = 1'b1; end
      OP_SHL:  ctl_o.unit = OUT_SHIFTSWAP;
      OP_RCL:  begin ctl_o.unit = OUT_SHIFTSWAP; ctl_o.cin_src = CIN_CARRY; end
      OP_SWAP: begin ctl_o.unit = OUT_SHIFTSWAP; ctl_o.alt = 1'b1; end
      OP_CMP:  begin ctl_o.alt = 1'b1; ctl_o.cin_src = CIN_ONE; ctl_o.writes_dst = 1'b0; end
      OP_MOV:  begin ctl_o.sets_flags = 1'b0; ctl_o.r_zero = 1'b1; end
      OP_ADDW: ctl_o.wide = 1'b1;
      OP_SUBW: begin ctl_o.wide = 1'b1; ctl_o.alt = 1'b1; ctl_o.cin_src = CIN_ONE; end
      default: begin
        ctl_o.unit       = OUT_NONE;
        ctl_o.writes_dst = 1'b0;
        ctl_o.sets_flags = 1'b0;
        ctl_o.nop        = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU control sequencer: one instruction at a time, two carry-chained passes for pair ops.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned CARRY_BIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  alu_sequencer_if.slave bus
);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [1:0] dst_q, dst_d, srcl_q, srcl_d, srcr_q, srcr_d;
  logic       accept;
  logic       carry;
  op_ctl_t    ctl;

  logic [3:0] outctl_q, outctl_d, loadctl_q, loadctl_d;
  logic [1:0] arg_l_q, arg_l_d;
  logic [2:0] arg_r_q, arg_r_d;
  logic       alt_q, alt_d, cin_q, cin_d, calcfn_q, calcfn_d;
  logic       busy_q, busy_d, done_q, done_d, ready_q, ready_d;

  logic       hi_half;
  logic [1:0] lreg, rreg, dreg;

  assign accept = (state_q == S_IDLE) && bus.cmd_valid;
  assign carry  = bus.flags[CARRY_BIT];

  // Decode the command about to be held, so outputs registered on the accept edge already reflect it.
  always_comb begin
    op_d   = op_q;
    dst_d  = dst_q;
    srcl_d = srcl_q;
    srcr_d = srcr_q;
    if (accept) begin
      op_d   = bus.cmd_op;
      dst_d  = bus.cmd_dst;
      srcl_d = bus.cmd_src_l;
      srcr_d = bus.cmd_src_r;
    end
  end

  alu_op_decode u_decode (.op_i(op_d), .ctl_o(ctl));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (bus.cmd_valid) state_d = ctl.nop ? S_DONE : S_SETUP;
      S_SETUP:  state_d = S_EXEC;
      S_EXEC:   state_d = ctl.wide ? S_SETUP2 : S_DONE;
      S_SETUP2: state_d = S_EXEC2;
      S_EXEC2:  state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are a function of the next state so they register in step with it.
  always_comb begin
    outctl_d  = OUT_NONE;
    loadctl_d = LOAD_NONE;
    arg_l_d   = '0;
    arg_r_d   = '0;
    alt_d     = 1'b0;
    cin_d     = 1'b0;
    calcfn_d  = 1'b1;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    ready_d   = 1'b0;
    hi_half   = (state_d == S_SETUP2) || (state_d == S_EXEC2);
    lreg      = srcl_d;
    rreg      = srcr_d;
    dreg      = dst_d;
    if (ctl.wide) begin
      lreg[0] = ~hi_half;
      rreg[0] = ~hi_half;
      dreg[0] = ~hi_half;
    end
    case (state_d)
      S_IDLE: ready_d = 1'b1;
      S_DONE: done_d  = 1'b1;
      default: begin
        busy_d  = 1'b1;
        alt_d   = ctl.alt;
        arg_l_d = lreg;
        arg_r_d = ctl.r_zero ? ARG_R_ZERO : {1'b0, rreg};
        if ((state_d == S_EXEC) || (state_d == S_EXEC2)) begin
          outctl_d  = ctl.unit;
          loadctl_d = ctl.writes_dst ? load_code(dreg) : LOAD_NONE;
          calcfn_d  = ~ctl.sets_flags;
          case (ctl.cin_src)
            CIN_ONE:   cin_d = 1'b1;
            CIN_CARRY: cin_d = carry;
            default:   cin_d = 1'b0;
          endcase
          if (state_d == S_EXEC2) cin_d = carry;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q      <= '0;
      dst_q     <= '0;
      srcl_q    <= '0;
      srcr_q    <= '0;
      outctl_q  <= OUT_NONE;
      loadctl_q <= LOAD_NONE;
      arg_l_q   <= '0;
      arg_r_q   <= '0;
      alt_q     <= 1'b0;
      cin_q     <= 1'b0;
      calcfn_q  <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      op_q      <= op_d;
      dst_q     <= dst_d;
      srcl_q    <= srcl_d;
      srcr_q    <= srcr_d;
      outctl_q  <= outctl_d;
      loadctl_q <= loadctl_d;
      arg_l_q   <= arg_l_d;
      arg_r_q   <= arg_r_d;
      alt_q     <= alt_d;
      cin_q     <= cin_d;
      calcfn_q  <= calcfn_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign bus.outctl    = outctl_q;
  assign bus.loadctl   = loadctl_q;
  assign bus.arg_l     = arg_l_q;
  assign bus.arg_r     = arg_r_q;
  assign bus.alt       = alt_q;
  assign bus.cin       = cin_q;
  assign bus.calcfn    = calcfn_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cmd_ready = ready_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that drives every control input of the ALU register/function block (register selects, bus output/load demux codes, `alt`, `cin`, `calcfn`). It sequences one ALU instruction at a time. It accepts a command over a valid/ready handshake and steps the datapath through operand setup and execute phases. Wide (16-bit register-pair) operations run two passes with carry chaining, and a one-cycle `done` pulse marks completion. It sits between the instruction decoder and the ALU block.

## Interface
Parameters:
- `CARRY_BIT`, default 1: index of the carry flag within `flags`.

Ports:
- `clk`  in  1: system clock. All state changes on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `cmd_valid`  in  1: command offered.
- `cmd_ready`  out  1: controller can accept a command.
- `cmd_op`  in  4: opcode (see Operation).
- `cmd_dst`  in  2: destination register (0=A, 1=B, 2=C, 3=D). For wide ops, bit 0 is ignored and the pair is {dst|0, dst|1}.
- `cmd_src_l`  in  2: left operand register.
- `cmd_src_r`  in  2: right operand register.
- `flags`  in  4: flag register output from the ALU block.
- `outctl`  out  4: bus output select code.
- `loadctl`  out  4: bus load select code.
- `arg_l`  out  2: left ALU operand select.
- `arg_r`  out  3: right ALU operand select. 6 = zero source.
- `alt`  out  1: function alternate (sub/or/not/swap).
- `cin`  out  1: ALU carry-in.
- `calcfn`  out  1: active-low flag-calculate enable.
- `busy`  out  1: sequence in progress.
- `done`  out  1: one-cycle completion pulse.

## Operation
- Output codes:
  - `outctl`: 2=addsub, 6=andor, 7=shiftswap, 10=xornot, 3=OUT_NONE (idle).
  - `loadctl`: A=0, B=1, C=8, D=9, 3=LOAD_NONE (idle). Flags are never loaded from the bus by this block.
- Opcodes (`alt`, `cin`, result unit):
  - ADD 0 (0, 0, addsub)
  - ADC 1 (0, C, addsub)
  - SUB 2 (1, 1, addsub)
  - SBC 3 (1, C, addsub)
  - AND 4 (0, –, andor)
  - OR 5 (1, –, andor)
  - XOR 6 (0, –, xornot)
  - NOT 7 (1, –, xornot)
  - SHL 8 (0, 0, shiftswap)
  - RCL 9 (0, C, shiftswap)
  - SWAP 10 (1, –, shiftswap)
  - CMP 11: as SUB, but `loadctl` stays LOAD_NONE.
  - MOV 12: ADD with `arg_r`=6; `calcfn` held high, so flags are not touched.
  - ADDW 13: pair add.
  - SUBW 14: pair subtract.
  - Codes 15 and above: NOP, completes with `done` and no datapath activity.
- C means `flags[CARRY_BIT]`, sampled in the cycle EXEC is entered.
- `cin` is 0 where marked –.
- States: IDLE, SETUP, EXEC, SETUP2, EXEC2, DONE.
  - IDLE: `cmd_ready`=1. On `cmd_valid`, latch the command and go to SETUP.
  - SETUP: drive `arg_l`/`arg_r`/`alt`; `outctl`/`loadctl` are idle codes. Go to EXEC.
  - EXEC: additionally drive `outctl`=unit, `loadctl`=dst, `calcfn`=0 (except MOV). Flags and destination latch at the end of this cycle.
  - After EXEC, wide ops go to SETUP2; all others go to DONE.
  - Wide low half uses the registers with bit0=1 (B or D) and `cin`=0 (ADDW) or 1 (SUBW).
  - SETUP2/EXEC2 handle the high half (bit0=0) with `cin`=C from the updated flags, `alt` unchanged.
  - DONE: `done`=1, `busy`=0, then return to IDLE.
- `cmd_valid` is ignored outside IDLE.

## Timing
- All outputs are registered.
- Reset values:
  - `outctl`=3, `loadctl`=3, `arg_l`=0, `arg_r`=0
  - `alt`=0, `cin`=0, `calcfn`=1
  - `busy`=0, `done`=0, `cmd_ready`=1
  - state IDLE
- Latency from accept edge to `done` high: 3 cycles for a narrow op, 5 for a wide op, 1 for NOP.
- Throughput: a new command can be accepted in the cycle after `done`. `cmd_ready` is low during `done`.
- `arg_*` are stable throughout SETUP and EXEC, so operands settle one full cycle before the load.
- `outctl`/`loadctl` are non-idle in EXEC/EXEC2 only, and never in two consecutive cycles.
- Reset asserted mid-sequence returns all outputs to reset values immediately (asynchronously); the command is lost and no `done` is issued.

## Structure
- Package `alu_seq_pkg` contains:
  - opcode enum
  - state enum
  - OUT_*/LOAD_* code constants, including OUT_NONE=3 and LOAD_NONE=3
  - ARG_R_ZERO=6
- Sub-module `alu_op_decode` is combinational: opcode → {unit code, `alt`, cin source, writes_dst, sets_flags, wide}. The FSM stays in the top module.

## Test plan
- Reset mid-EXEC: assert `rst` low during EXEC of an ADD → `loadctl`=3, `calcfn`=1, `cmd_ready`=1 immediately; no `done`.
- ADD dst=A, l=A, r=B → exactly one EXEC cycle with `outctl`=2, `loadctl`=0, `arg_l`=0, `arg_r`=1, `cin`=0, `calcfn`=0; `done` 3 cycles after accept.
- ADC with `flags[1]`=1 → `cin`=1. CMP → `loadctl` stays 3 throughout while `calcfn`=0 in EXEC.
- ADDW dst=A, l=A, r=C:
  - EXEC: `arg_l`=1, `arg_r`=3, `loadctl`=1, `cin`=0.
  - Model flags to carry=1 after EXEC.
  - EXEC2: `arg_l`=0, `arg_r`=2, `loadctl`=0, `cin`=1.
  - `done` at cycle 5.
- MOV dst=D, src_l=B → EXEC has `arg_r`=6, `outctl`=2, `loadctl`=9, `calcfn`=1.
- Back-to-back commands held valid: second accepted only after `done`. Opcode 15 → `done` 1 cycle after accept with `outctl`/`loadctl` idle.
